dec_addr_sequencer: RTL and testbench
=====================================

# dec_addr_sequencer

Registered address sequencer that drives the 3-bit select input of the 3-to-8 decoder. It steps a code from FIRST to LAST and holds each code for DWELL cycles, so the decoder's one-hot output scans its 8 lines in order. It supports pause, abort and continuous looping, and reports status through a start/busy/done handshake. The block sits directly upstream of the decoder: A connects to the decoder select, and a_valid qualifies the decoded line for downstream logic.

## Interface
- DWELL, 4: cycles each code is held; legal range 1..255; held in an 8-bit counter.
- FIRST, 0: first code of a scan, 3 bits.
- LAST, 7: last code of a scan, 3 bits; FIRST <= LAST is required.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  level sampled in IDLE; begins a scan.
- stop  in  1  abort; highest priority after reset.
- hold  in  1  freeze the current code and dwell count.
- loop  in  1  at LAST expiry, restart at FIRST instead of finishing.
- A  out  3  registered select code to the decoder.
- a_valid  out  1  A is a live scan code.
- busy  out  1  high in RUN and PAUSE.
- done  out  1  one-cycle pulse after a scan completes normally.

## Operation
- Reset (rst_n=0 at an edge): state IDLE, A=FIRST, a_valid=0, busy=0, done=0, dwell_cnt=0.
- Priority at each edge: rst_n, then stop, then hold, then dwell expiry, then start.
- States are IDLE, RUN, PAUSE and DONE.
- **IDLE**
  - start=1 and stop=0: go to RUN; A=FIRST, a_valid=1, busy=1, dwell_cnt=0.
  - A otherwise keeps its last value; a_valid=0.
- **RUN**
  - hold=0: dwell_cnt increments each cycle.
  - Expiry is dwell_cnt==DWELL-1. On expiry dwell_cnt goes to 0, then:
    - If A!=LAST: A=A+1.
    - If A==LAST and loop=1: A=FIRST.
    - If A==LAST and loop=0: go to DONE with a_valid=0 and busy=0.
  - hold=1: go to PAUSE.
  - stop=1: go to IDLE; a_valid=0, busy=0, no done pulse.
- **PAUSE**
  - A, a_valid=1, busy=1 and dwell_cnt are all frozen.
  - hold=0: return to RUN; the count resumes at the frozen value.
  - stop=1: go to IDLE as in RUN.
- **DONE**
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - start is ignored in this state.
- start is ignored while busy=1.
- start=1 and stop=1 together in IDLE: the block stays in IDLE.
- loop is sampled only at LAST expiry; clearing it mid-scan lets the current pass finish with done.
- A never leaves the range [FIRST, LAST] while a_valid=1; no 3-bit wrap-around beyond LAST.
- rst_n=0 in any state forces the reset values at that edge, with no done pulse.

## Timing
- All outputs are registered. The first A=FIRST with a_valid=1 appears in the cycle after the edge that samples start=1 in IDLE.
- With no hold, a_valid=1 for exactly (LAST-FIRST+1)*DWELL cycles.
- done is high in the cycle immediately after the last a_valid=1 cycle; busy falls in that same cycle.
- Every hold=1 cycle in RUN or PAUSE extends the scan by exactly one cycle.
- stop takes effect at the next edge: a_valid=0 and busy=0 in the following cycle.
- From done high, a new start can be sampled 2 edges later, at the earliest once the block is back in IDLE.

## Configuration
- SEQ_DOWN_EN defined:
  - Adds port dir (in, 1). dir is latched on the edge that leaves IDLE.
  - dir=1 scans LAST down to FIRST: the start code is LAST, the step is A-1, and the terminal code is FIRST.
  - dir=0 behaves exactly as the undefined case.
- SEQ_DOWN_EN undefined: no dir port; the scan is always ascending.

## Test plan
- Defaults, DWELL=2, one-cycle start pulse: A=0,0,1,1,…,7,7 with a_valid=1 for 16 cycles; done=1 in cycle 17 only; busy=0 from cycle 17.
- DWELL=2, hold=1 for 3 cycles while A=3: A=3 is held for 5 cycles total; a_valid stays 1; done appears at cycle 20; the code order is unchanged.
- stop=1 for one cycle while A=5: next cycle a_valid=0, busy=0, state IDLE; done stays 0; a later start restarts at A=0.
- loop=1: after A=7 expires, A=0 with no done pulse. Clear loop during the second pass: done pulses after the second A=7 expires.
- rst_n=0 for one edge while A=4 mid-run: next cycle A=0, a_valid=0, busy=0, done=0. start during DONE, and start+stop together in IDLE, both leave the block IDLE.
- SEQ_DOWN_EN, dir=1, FIRST=2, LAST=6, DWELL=1: A=6,5,4,3,2 over 5 cycles, then done=1 for one cycle.

Source files
------------

// File: rtl/dec_addr_sequencer_if.sv
// Handshake bundle between a scan controller and dec_addr_sequencer.
// SEQ_DOWN_EN adds the dir (scan direction) signal.
interface dec_addr_sequencer_if;
  logic       start;
  logic       stop;
  logic       hold;
  logic       loop;
`ifdef SEQ_DOWN_EN
  logic       dir;
`endif
  logic [2:0] A;
  logic       a_valid;
  logic       busy;
  logic       done;

`ifdef SEQ_DOWN_EN
  modport master (output start, stop, hold, loop, dir, input A, a_valid, busy, done);
  modport slave  (input start, stop, hold, loop, dir, output A, a_valid, busy, done);
`else
  modport master (output start, stop, hold, loop, input A, a_valid, busy, done);
  modport slave  (input start, stop, hold, loop, output A, a_valid, busy, done);
`endif
endinterface

// File: rtl/dec_addr_sequencer.sv
// Registered select-code sequencer for a 3-to-8 decoder: scans FIRST..LAST, DWELL cycles per code.
// Optional feature macro: SEQ_DOWN_EN (adds dir input for descending scans).
module dec_addr_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter logic [2:0]  FIRST = 3'd0,
  parameter logic [2:0]  LAST  = 3'd7
) (
  input logic                 clk,
  input logic                 rst_n,
  dec_addr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic       a_valid_q, a_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] dwell_cnt_q, dwell_cnt_d;

  logic       expired;
  logic [2:0] scan_first, scan_term, scan_step, idle_first;

`ifdef SEQ_DOWN_EN
  logic down_q, down_d;

  // Direction is captured only when a scan is launched so a mid-scan change cannot skew it.
  always_comb begin
    down_d = down_q;
    if (state_q == S_IDLE && bus.start && !bus.stop) down_d = bus.dir;
  end

  assign idle_first = bus.dir ? LAST : FIRST;
`else
  logic down_q;
  assign down_q     = 1'b0;
  assign idle_first = FIRST;
`endif

  assign expired    = (dwell_cnt_q == DWELL_LAST);
  assign scan_first = down_q ? LAST  : FIRST;
  assign scan_term  = down_q ? FIRST : LAST;
  assign scan_step  = down_q ? (a_q - 3'd1) : (a_q + 3'd1);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    a_valid_d   = a_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        a_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d     = S_RUN;
          a_d         = idle_first;
          a_valid_d   = 1'b1;
          busy_d      = 1'b1;
          dwell_cnt_d = 8'd0;
        end
      end
      S_RUN, S_PAUSE: begin
        if (bus.stop) begin
          state_d     = S_IDLE;
          a_valid_d   = 1'b0;
          busy_d      = 1'b0;
          dwell_cnt_d = 8'd0;
        end else if (bus.hold) begin
          state_d = S_PAUSE;
        end else begin
          // Leaving PAUSE counts as a live cycle, so each hold cycle costs exactly one cycle.
          state_d = S_RUN;
          if (expired) begin
            dwell_cnt_d = 8'd0;
            if (a_q != scan_term) begin
              a_d = scan_step;
            end else if (bus.loop) begin
              a_d = scan_first;
            end else begin
              state_d   = S_DONE;
              a_valid_d = 1'b0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        a_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        a_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= FIRST;
      a_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      a_valid_q   <= a_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

`ifdef SEQ_DOWN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) down_q <= 1'b0;
    else        down_q <= down_d;
  end
`endif

  assign bus.A       = a_q;
  assign bus.a_valid = a_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_dec_addr_sequencer.sv
// Directed bench for dec_addr_sequencer (DWELL=2, FIRST=0, LAST=7): table vectors plus corner sequences.
module tb_dec_addr_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  dec_addr_sequencer_if bus();

  dec_addr_sequencer #(.DWELL(2), .FIRST(3'd0), .LAST(3'd7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, hold, loop, rn;
    logic [2:0] a;
    logic       v, b, d;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, logic hd, logic lp, logic rn,
                              logic [2:0] a, logic v, logic b, logic d, string nm);
    vec_t r;
    r.start = st; r.stop = sp; r.hold = hd; r.loop = lp; r.rn = rn;
    r.a = a; r.v = v; r.b = b; r.d = d; r.nm = nm;
    return r;
  endfunction

  // Drive one cycle of inputs, clock it, and compare the registered outputs after the edge.
  task automatic cyc(input logic st, input logic sp, input logic hd, input logic lp, input logic rn,
                     input logic [2:0] ea, input logic ev, input logic eb, input logic ed,
                     input string nm);
    logic [5:0] got, exp;
    bus.start = st; bus.stop = sp; bus.hold = hd; bus.loop = lp; rst_n = rn;
    @(posedge clk);
    #1;
    got = {bus.A, bus.a_valid, bus.busy, bus.done};
    exp = {ea, ev, eb, ed};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got A=%0d v=%b b=%b d=%b, want A=%0d v=%b b=%b d=%b",
               nm, n_vec, got[5:3], got[2], got[1], got[0], ea, ev, eb, ed);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.loop = 1'b0;
`ifdef SEQ_DOWN_EN
    bus.dir = 1'b0;
`endif
    rst_n = 1'b0;

    // Reset, a full ascending scan, then start during DONE and start+stop in IDLE.
    tbl.push_back(mk(0,0,0,0,0, 3'd0,0,0,0, "reset"));
    tbl.push_back(mk(0,0,0,0,0, 3'd0,0,0,0, "reset"));
    tbl.push_back(mk(0,0,0,0,1, 3'd0,0,0,0, "idle_after_reset"));
    tbl.push_back(mk(1,0,0,0,1, 3'd0,1,1,0, "scan"));
    for (int k = 1; k < 16; k++)
      tbl.push_back(mk(0,0,0,0,1, 3'(k/2),1,1,0, "scan"));
    tbl.push_back(mk(0,0,0,0,1, 3'd7,0,0,1, "scan_done"));
    tbl.push_back(mk(1,0,0,0,1, 3'd7,0,0,0, "start_in_done"));
    tbl.push_back(mk(1,1,0,0,1, 3'd7,0,0,0, "start_stop_idle"));
    tbl.push_back(mk(0,0,0,0,1, 3'd7,0,0,0, "idle_hold"));
    tbl.push_back(mk(1,0,0,0,1, 3'd0,1,1,0, "restart"));
    tbl.push_back(mk(0,1,0,0,1, 3'd0,0,0,0, "stop_cleanup"));

    foreach (tbl[i])
      cyc(tbl[i].start, tbl[i].stop, tbl[i].hold, tbl[i].loop, tbl[i].rn,
          tbl[i].a, tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].nm);

    // Three hold cycles while A=3: A=3 seen 5 cycles, done in cycle 20.
    cyc(1,0,0,0,1, 3'd0,1,1,0, "hold_start");
    for (int k = 1; k <= 6; k++) cyc(0,0,0,0,1, 3'(k/2),1,1,0, "hold_pre");
    for (int k = 0; k < 3; k++)  cyc(0,0,1,0,1, 3'd3,1,1,0, "hold_pause");
    cyc(0,0,0,0,1, 3'd3,1,1,0, "hold_resume");
    for (int k = 8; k < 16; k++) cyc(0,0,0,0,1, 3'(k/2),1,1,0, "hold_post");
    cyc(0,0,0,0,1, 3'd7,0,0,1, "hold_done");
    cyc(0,0,0,0,1, 3'd7,0,0,0, "hold_idle");

    // Stop while A=5: idle next cycle, no done, restart from FIRST.
    cyc(1,0,0,0,1, 3'd0,1,1,0, "stop_start");
    for (int k = 1; k <= 10; k++) cyc(0,0,0,0,1, 3'(k/2),1,1,0, "stop_pre");
    cyc(0,1,0,0,1, 3'd5,0,0,0, "stop_abort");
    cyc(0,0,0,0,1, 3'd5,0,0,0, "stop_no_done");
    cyc(1,0,0,0,1, 3'd0,1,1,0, "stop_restart");
    cyc(0,0,0,0,1, 3'd0,1,1,0, "stop_restart2");
    cyc(0,1,0,0,1, 3'd0,0,0,0, "stop_cleanup2");

    // Loop: wrap to 0 with no done, then clear loop so pass two finishes.
    cyc(1,0,0,1,1, 3'd0,1,1,0, "loop_start");
    for (int k = 1; k < 16; k++) cyc(0,0,0,1,1, 3'(k/2),1,1,0, "loop_pass1");
    cyc(0,0,0,1,1, 3'd0,1,1,0, "loop_wrap");
    for (int k = 17; k < 32; k++) cyc(0,0,0,0,1, 3'((k-16)/2),1,1,0, "loop_pass2");
    cyc(0,0,0,0,1, 3'd7,0,0,1, "loop_done");
    cyc(0,0,0,0,1, 3'd7,0,0,0, "loop_idle");

    // Reset mid-run while A=4.
    cyc(1,0,0,0,1, 3'd0,1,1,0, "rst_start");
    for (int k = 1; k <= 8; k++) cyc(0,0,0,0,1, 3'(k/2),1,1,0, "rst_pre");
    cyc(0,0,0,0,0, 3'd0,0,0,0, "rst_mid");
    cyc(0,0,0,0,1, 3'd0,0,0,0, "rst_idle");

`ifdef SEQ_DOWN_EN
    // Descending scan: 7,7,6,6,...,0,0 then done.
    bus.dir = 1'b1;
    cyc(1,0,0,0,1, 3'd7,1,1,0, "down_start");
    bus.dir = 1'b0;
    for (int k = 1; k < 16; k++) cyc(0,0,0,0,1, 3'(7 - k/2),1,1,0, "down_scan");
    cyc(0,0,0,0,1, 3'd0,0,0,1, "down_done");
    cyc(0,0,0,0,1, 3'd0,0,0,0, "down_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
